// File: rtl/processor_pkg.sv
// Shared constants and types for the staged processor front end.
// Fetch-queue entry layout and default sizing live here.
package processor_pkg;

  localparam int ADDR_SIZE_DEFAULT   = 18;
  localparam int WORD_SIZE_DEFAULT   = 18;
  localparam int FETCH_DEPTH_DEFAULT = 4;
  localparam int RESET_IP_DEFAULT    = 0;

  typedef struct packed {
    logic [ADDR_SIZE_DEFAULT-1:0] ip;
    logic [WORD_SIZE_DEFAULT-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Prefetch queue storage: one write port, async read at the head.
// Data is not reset; occupancy is tracked by the owner's count.
module fetch_queue_mem
  import processor_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int WIDTH = ADDR_SIZE_DEFAULT + WORD_SIZE_DEFAULT,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/processor_fetch_queue.sv
// Instruction-fetch front end: sequential code reads into a
// DEPTH-entry prefetch queue drained by decode via valid/ready.
module processor_fetch_queue
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
  parameter int DEPTH     = FETCH_DEPTH_DEFAULT,
  parameter int RESET_IP  = RESET_IP_DEFAULT,
  localparam int QW = $clog2(DEPTH+1),
  localparam int CW = QW + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [WORD_SIZE-1:0] code_word,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_ip,
  output logic                 out_valid,
  output logic [ADDR_SIZE-1:0] out_ip,
  output logic [WORD_SIZE-1:0] out_word,
  input  logic                 out_ready,
  output logic [QW-1:0]        queue_count
);

  logic [ADDR_SIZE-1:0] fetch_ip;
  logic [ADDR_SIZE-1:0] pending_ip;
  logic                 pending;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [QW-1:0]        count_r;
  logic [QW-1:0]        count_next;
  logic [CW-1:0]        credit;
  logic                 fire;
  logic                 push;
  logic                 pop;

  logic [ADDR_SIZE+WORD_SIZE-1:0] head;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid   = (count_r != '0);
  assign pop         = out_valid && out_ready;
  assign push        = pending && !redirect_valid;
  assign queue_count = count_r;
  assign code_addr   = fetch_ip;

  // In-flight read holds a slot so its push can never overflow.
  assign credit = CW'(count_r) + CW'(pending) - CW'(pop);
  assign fire   = !halt && !redirect_valid
                && (credit < CW'(DEPTH));

  always_comb begin
    count_next = count_r;
    unique case (1'b1)
      push && !pop: count_next = count_r + 1'b1;
      pop && !push: count_next = count_r - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_ip   <= ADDR_SIZE'(RESET_IP);
      pending_ip <= '0;
      pending    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
    end else if (redirect_valid) begin
      fetch_ip <= redirect_ip;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_r  <= '0;
    end else begin
      pending <= fire;
      if (fire) begin
        pending_ip <= fetch_ip;
        fetch_ip   <= fetch_ip + 1'b1;
      end
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      count_r <= count_next;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_SIZE + WORD_SIZE)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({pending_ip, code_word}),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  assign out_ip   = head[ADDR_SIZE+WORD_SIZE-1:WORD_SIZE];
  assign out_word = head[WORD_SIZE-1:0];

endmodule

// File: tb/tb_processor_fetch_queue.sv
// Bench for processor_fetch_queue: directed scenarios plus random
// ready/halt/redirect against an expected-ip stream scoreboard.
module tb_processor_fetch_queue;
  import processor_pkg::*;

  localparam int A  = 18;
  localparam int W  = 18;
  localparam int D  = 4;
  localparam int QW = $clog2(D+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [A-1:0]  code_addr;
  logic [W-1:0]  code_word = '0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [A-1:0]  redirect_ip = '0;
  logic          out_valid;
  logic [A-1:0]  out_ip;
  logic [W-1:0]  out_word;
  logic          out_ready = 1'b0;
  logic [QW-1:0] queue_count;

  int checks = 0;
  int errors = 0;

  logic [A-1:0] exp_ip = '0;

  processor_fetch_queue #(
    .ADDR_SIZE (A),
    .WORD_SIZE (W),
    .DEPTH     (D),
    .RESET_IP  (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .code_addr      (code_addr),
    .code_word      (code_word),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_ip    (redirect_ip),
    .out_valid      (out_valid),
    .out_ip         (out_ip),
    .out_word       (out_word),
    .out_ready      (out_ready),
    .queue_count    (queue_count)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] rom(input logic [A-1:0] a);
    return W'(a) + W'(100);
  endfunction

  always @(posedge clock) code_word <= rom(code_addr);

  // Scoreboard: the head must always be the next ip of the stream.
  always @(negedge clock) begin
    fetch_entry_t got, want;
    if (!reset) begin
      exp_ip = '0;
    end else begin
      if (out_valid) begin
        got  = '{ip: out_ip, word: out_word};
        want = '{ip: exp_ip, word: rom(exp_ip)};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL head got=%h want=%h", got, want);
        end
      end
      checks++;
      if (queue_count > QW'(D) ||
          out_valid !== (queue_count != 0)) begin
        errors++;
        $display("FAIL occupancy count=%0d valid=%b",
                 queue_count, out_valid);
      end
      if (out_valid && out_ready) exp_ip = exp_ip + 1'b1;
      if (redirect_valid) exp_ip = redirect_ip;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic restart();
    halt = 0;
    redirect_valid = 0;
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    out_ready = 1;
    #3;
    checks++;
    if (out_valid !== 0 || queue_count !== 0 || code_addr !== 0) begin
      errors++;
      $display("FAIL reset_state valid=%b count=%0d addr=%h",
               out_valid, queue_count, code_addr);
    end
    step();
    reset = 1;
    step();
    checks++;
    if (out_valid !== 0 || code_addr !== 1) begin
      errors++;
      $display("FAIL edge1 valid=%b addr=%h want 0/1",
               out_valid, code_addr);
    end
    step();
    checks++;
    if (out_valid !== 1 || out_ip !== 0 || out_word !== 100
        || code_addr !== 2) begin
      errors++;
      $display("FAIL edge2 valid=%b ip=%h word=%0d addr=%h",
               out_valid, out_ip, out_word, code_addr);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1 || out_ip !== A'(i)) begin
        errors++;
        $display("FAIL stream valid=%b ip=%h want %h",
                 out_valid, out_ip, i);
      end
    end
  endtask

  task automatic test_full();
    out_ready = 0;
    restart();
    step(10);
    checks++;
    if (queue_count !== QW'(D) || code_addr !== 4 || out_ip !== 0) begin
      errors++;
      $display("FAIL full count=%0d addr=%h ip=%h want 4/4/0",
               queue_count, code_addr, out_ip);
    end
    out_ready = 1;
    step();
    checks++;
    if (code_addr !== 5) begin
      errors++;
      $display("FAIL resume addr=%h want 5", code_addr);
    end
    for (int i = 1; i <= 7; i++) begin
      checks++;
      if (out_valid !== 1 || out_ip !== A'(i)) begin
        errors++;
        $display("FAIL drain valid=%b ip=%h want %h",
                 out_valid, out_ip, i);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    out_ready = 0;
    restart();
    step(4);
    checks++;
    if (queue_count !== 3) begin
      errors++;
      $display("FAIL prefill count=%0d want 3", queue_count);
    end
    redirect_valid = 1;
    redirect_ip = 18'h200;
    step();
    redirect_valid = 0;
    checks++;
    if (queue_count !== 0 || out_valid !== 0 || code_addr !== 18'h200) begin
      errors++;
      $display("FAIL flush count=%0d valid=%b addr=%h",
               queue_count, out_valid, code_addr);
    end
    step();
    checks++;
    if (out_valid !== 0) begin
      errors++;
      $display("FAIL squash valid=%b want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1 || out_ip !== 18'h200
        || out_word !== rom(18'h200)) begin
      errors++;
      $display("FAIL target valid=%b ip=%h word=%h",
               out_valid, out_ip, out_word);
    end
    out_ready = 1;
    step(6);
  endtask

  task automatic test_redirect_collide();
    logic [A-1:0] tgt;
    out_ready = 1;
    restart();
    step(5);
    checks++;
    if (out_valid !== 1 || queue_count !== 1) begin
      errors++;
      $display("FAIL steady valid=%b count=%0d want 1/1",
               out_valid, queue_count);
    end
    tgt = A'($urandom);
    redirect_valid = 1;
    redirect_ip = tgt;
    step();
    redirect_valid = 0;
    checks++;
    if (queue_count !== 0 || code_addr !== tgt) begin
      errors++;
      $display("FAIL collide count=%0d addr=%h want 0/%h",
               queue_count, code_addr, tgt);
    end
    step(2);
    checks++;
    if (out_valid !== 1 || out_ip !== tgt) begin
      errors++;
      $display("FAIL collide_target ip=%h want %h", out_ip, tgt);
    end
    step(4);
  endtask

  task automatic test_halt();
    logic [A-1:0] a;
    out_ready = 1;
    restart();
    step(5);
    halt = 1;
    a = code_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (code_addr !== a) begin
        errors++;
        $display("FAIL halt_addr addr=%h want %h", code_addr, a);
      end
    end
    checks++;
    if (queue_count !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL halt_drain count=%0d valid=%b",
               queue_count, out_valid);
    end
    halt = 0;
    step(2);
    checks++;
    if (out_valid !== 1 || out_ip !== a) begin
      errors++;
      $display("FAIL halt_resume ip=%h want %h", out_ip, a);
    end
    step(3);
  endtask

  task automatic test_wrap();
    logic [A-1:0] want;
    out_ready = 1;
    restart();
    step(3);
    redirect_valid = 1;
    redirect_ip = 18'h3FFFE;
    step();
    redirect_valid = 0;
    step(2);
    want = 18'h3FFFE;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1 || out_ip !== want) begin
        errors++;
        $display("FAIL wrap ip=%h want %h", out_ip, want);
      end
      want = want + 1'b1;
      step();
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (out_valid !== 0 || queue_count !== 0 || code_addr !== 0) begin
      errors++;
      $display("FAIL async_reset valid=%b count=%0d addr=%h",
               out_valid, queue_count, code_addr);
    end
    step();
    reset = 1;
    step(2);
    checks++;
    if (out_valid !== 1 || out_ip !== 0) begin
      errors++;
      $display("FAIL restart ip=%h valid=%b want 0/1",
               out_ip, out_valid);
    end
  endtask

  task automatic test_random();
    int pops;
    pops = 0;
    restart();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_ip = A'($urandom);
      #2;
      if (out_valid && out_ready) pops++;
      step();
    end
    halt = 0;
    redirect_valid = 0;
    out_ready = 1;
    step(4);
    checks++;
    if (pops < 100) begin
      errors++;
      $display("FAIL random_progress pops=%0d want >=100", pops);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_redirect();
    test_redirect_collide();
    test_halt();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
